sync_fifo_core: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 48 ++++
 rtl/sync_fifo_core.sv | 104 ++++++++++
 tb/tb_sync_fifo_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared defaults for the synchronous FIFO core and its storage array.
//   DEF_DATA_WIDTH : default stored word width
//   DEF_DEPTH      : default entry count (power of two, >= 2)
//   DEF_ADDR_WIDTH : index width derived from DEF_DEPTH
//   ptr_t          : pointer type for the default depth (index + wrap bit)
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

    // One extra MSB distinguishes "same index, same lap" (empty) from
    // "same index, one lap apart" (full).
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// synchronous, enabled read port. No reset: contents and the read register
// are don't-care until written/loaded.
// Ports:
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write index
//   wr_data_i  : write word
//   rd_en_i    : read strobe; rd_data_o updates only when set
//   rd_addr_i  : read index
//   rd_data_o  : registered read word
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : fifo_mem

// File: rtl/sync_fifo_core.sv
// ---------------------------------------------------------------------------
// sync_fifo_core
// Single-clock FIFO: DEPTH-entry circular buffer with registered read data
// and full/empty flags decoded from the registered pointers.
// Ports:
//   clk          : sole clock, rising edge
//   rst          : asynchronous active-low reset
//   write_enable : write request; accepted when !full
//   write_data   : word to store
//   read_enable  : read request; accepted when !empty
//   read_data    : registered read word (0 after reset until first read)
//   full         : FIFO holds DEPTH words
//   empty        : FIFO holds 0 words
//   level        : occupancy 0..DEPTH (only when FIFO_LEVEL_EN is defined)
// Handshake: a request is taken on a rising edge exactly when its enable is
// high and the matching flag (full for writes, empty for reads) is low in
// that cycle; refused requests have no effect and need no retry signalling.
// Build option: define FIFO_LEVEL_EN to add the level output.
// ---------------------------------------------------------------------------
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
`ifdef FIFO_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level,
`endif
    output logic                  full,
    output logic                  empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_core: DEPTH must be a power of two and >= 2");
    end

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  rd_seen_q, rd_seen_d;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                    (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    assign wr_acc = write_enable && !full;
    assign rd_acc = read_enable && !empty;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_seen_d = rd_seen_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d    = rptr_q + 1'b1;
            rd_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (write_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (mem_rdata)
    );

    // The storage read register has no reset; rd_seen_q forces read_data to
    // zero from reset (asynchronously) until the first accepted read.
    assign read_data = rd_seen_q ? mem_rdata : '0;

`ifdef FIFO_LEVEL_EN
    // Modular subtraction of the wrap-extended pointers yields 0..DEPTH.
    assign level = wptr_q - rptr_q;
`endif

endmodule : sync_fifo_core

// File: tb/tb_sync_fifo_core.sv
module tb_sync_fifo_core;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         write_enable = 1'b0;
  logic [W-1:0] write_data = '0;
  logic         read_enable = 1'b0;
  logic [W-1:0] read_data;
  logic         full;
  logic         empty;
`ifdef FIFO_LEVEL_EN
  logic [3:0]   level;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model: queue of stored words plus last read word
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd = '0;

  sync_fifo_core dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
`ifdef FIFO_LEVEL_EN
    .level        (level),
`endif
    .full         (full),
    .empty        (empty)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // model update: occupancy rules applied to a plain queue
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      exp_rd = '0;
    end else begin
      bit wacc;
      bit racc;
      wacc = write_enable && (exp_q.size() < DEPTH);
      racc = read_enable && (exp_q.size() > 0);
      if (racc) exp_rd = exp_q.pop_front();
      if (wacc) exp_q.push_back(write_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sb_empty", {31'b0, empty}, {31'b0, exp_q.size() == 0});
      chk("sb_full", {31'b0, full}, {31'b0, exp_q.size() == DEPTH});
      chk("sb_read_data", {24'b0, read_data}, {24'b0, exp_rd});
`ifdef FIFO_LEVEL_EN
      chk("sb_level", {28'b0, level}, exp_q.size());
`endif
    end
  end

  // driver: apply inputs for one edge, return 2 time units after that edge
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    #2;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] last;
    // reset held for 2 cycles
    #3 rst = 1'b0;
    #1;
    cmp_en = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_read_data", {24'b0, read_data}, 32'h00);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("idle_empty", {31'b0, empty}, 32'd1);
    chk("idle_full", {31'b0, full}, 32'd0);

    // fill 0x01..0x08 then a dropped 0x09
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, W'(i), 1'b0);
      if (i == 1) chk("fill_empty_after_first", {31'b0, empty}, 32'd0);
      if (i == 7) chk("fill_not_full_at_7", {31'b0, full}, 32'd0);
      if (i >= 8) chk("fill_full", {31'b0, full}, 32'd1);
    end

    // drain with 10 reads
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_data", {24'b0, read_data}, (i <= 8) ? i : 8);
      if (i >= 8) chk("drain_empty", {31'b0, empty}, 32'd1);
      chk("drain_full", {31'b0, full}, 32'd0);
    end

    // simultaneous with 3 entries held
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'(8'h33 + i), 1'b1);
      chk("sim_data", {24'b0, read_data}, 32'h30 + i);
`ifdef FIFO_LEVEL_EN
      chk("sim_level", {28'b0, level}, 32'd3);
`endif
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      chk("sim_drain", {24'b0, read_data}, 32'h35 + i);
    end
    chk("sim_empty", {31'b0, empty}, 32'd1);
    // simultaneous on empty: only the write lands
    step(1'b1, 8'hAA, 1'b1);
    chk("nofall_empty", {31'b0, empty}, 32'd0);
    chk("nofall_data", {24'b0, read_data}, 32'h37);
    step(1'b0, '0, 1'b1);
    chk("nofall_read", {24'b0, read_data}, 32'hAA);

    // wrap: 20 write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1'b1, W'(8'h10 + i), 1'b0);
      chk("wrap_not_empty", {31'b0, empty}, 32'd0);
      step(1'b0, '0, 1'b1);
      chk("wrap_data", {24'b0, read_data}, 32'h10 + i);
      chk("wrap_empty", {31'b0, empty}, 32'd1);
    end

    // random traffic, biased to reach both full and empty
    for (int i = 0; i < 400; i++) begin
      logic we, re;
      if (i < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      step(we, W'($urandom_range(0, 255)), re);
    end

    // mid-operation reset with 5 entries held
    while (!empty) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h50 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    last = read_data;
    chk("pre_rst_data", {24'b0, last}, 32'h50);
    rst = 1'b0;
    #1;
    chk("arst_empty", {31'b0, empty}, 32'd1);
    chk("arst_full", {31'b0, full}, 32'd0);
    chk("arst_read_data", {24'b0, read_data}, 32'h00);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    step(1'b0, '0, 1'b1);
    chk("post_rst_read_ignored", {24'b0, read_data}, 32'h00);
    chk("post_rst_empty", {31'b0, empty}, 32'd1);
    step(1'b1, 8'h66, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_fresh", {24'b0, read_data}, 32'h66);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
